// File: rtl/memory_wait.sv
// rtl/memory_wait.sv - Wishbone classic RAM slave with wait states, window decode and error termination
module memory_wait #(
    parameter logic [31:0] BASE_ADDRESS = 32'h2000_0000,
    parameter int unsigned SIZE         = 32'h4000,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [31:0]             adr_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    rty_o
);

    localparam int unsigned SEL_W = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = SIZE / SEL_W;
    localparam int unsigned OFF_W = $clog2(SEL_W);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        RECOVER
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [3:0]              cnt;
    logic [3:0]              cnt_d;
    logic                    latch;
    logic                    respond;
    logic [31:0]             offset;
    logic                    hit;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_q;
    logic                    we_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Offset is only meaningful when adr_i is at or above the base; the
    // lower-bound compare guards the wrap-around case.
    assign offset = adr_i - BASE_ADDRESS;
    assign hit    = cyc_i && stb_i && (adr_i >= BASE_ADDRESS) && (offset < SIZE);
    assign idx    = offset[OFF_W +: IDX_W];
    assign rty_o  = 1'b0;

    // Next-state logic: accept in IDLE, count wait states, respond once, then rest one cycle
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        latch   = 1'b0;
        respond = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!(cyc_i && stb_i)) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP: begin
                respond = 1'b1;
                state_d = RECOVER;
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Request capture; held until the response so the bus may change meanwhile
    always_ff @(posedge clk_i) begin
        if (latch) begin
            idx_q <= idx;
            we_q  <= we_i;
            sel_q <= sel_i;
            dat_q <= dat_i;
        end
    end

    // Lane-masked write; reset on the same edge suppresses the commit
    always_ff @(posedge clk_i) begin
        if (respond && !rst_i && we_q) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (sel_q[i]) begin
                    mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
                end
            end
        end
    end

    // Registered termination; dat_o is zero outside a read ack so it can be OR-muxed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= respond && (sel_q != '0);
            err_o <= respond && (sel_q == '0);
            dat_o <= (respond && (sel_q != '0) && !we_q) ? mem[idx_q] : '0;
        end
    end

endmodule
